a2d_conv_seq: RTL and testbench

- Scheduler that time-shares the single SPI A2D converter across the four eBike analog channels: BATT, CURR, BRAKE and TORQUE.
- Issues a two-transaction conversion per channel in round-robin order, paced by an interval timer.
- Holds the latest 12-bit result per channel in registers for the sensor/telemetry logic.
- Sits between the SPI main-side transceiver and the eBike sensor_cndtn / telemetry logic.

---
 rtl/a2d_seq_pkg.sv | 32 +++
 rtl/a2d_slot_avg.sv | 47 ++++
 rtl/a2d_conv_seq.sv | 143 ++++++++++++++
 tb/tb_a2d_conv_seq.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_seq_pkg.sv
`default_nettype none
// =============================================================================
// Module   : a2d_seq_pkg
// Brief    : Shared types, slot/channel map and command builder for the A2D
//            conversion scheduler (optional averaging macro: A2D_SEQ_AVG_EN).
// Revision : 1.0
// =============================================================================
package a2d_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        GAP  = 2'd2,
        RD   = 2'd3
    } state_t;

    localparam int C_NUM_SLOTS  = 4;
    localparam int C_SAMP_W     = 12;
    localparam int C_ACC_W      = 14;
    localparam int C_AVG_DEPTH  = 4;
    localparam int C_TMR_W_FAST = 10;
    localparam int C_TMR_W_SLOW = 16;

    // Slot 0..3 -> A2D channel 0,1,3,4 (BATT, CURR, BRAKE, TORQUE)
    localparam logic [C_NUM_SLOTS-1:0][2:0] C_SLOT_CHNL = {3'd4, 3'd3, 3'd1, 3'd0};

    function automatic logic [15:0] cmd_word(input logic [1:0] slot);
        return {2'b00, C_SLOT_CHNL[slot], 11'h000};
    endfunction

endpackage
`default_nettype wire

// File: rtl/a2d_slot_avg.sv
`default_nettype none
// =============================================================================
// Module   : a2d_slot_avg
// Brief    : Per-slot result register; with A2D_SEQ_AVG_EN defined it holds a
//            4-sample history and outputs the running mean.
// Revision : 1.0
// =============================================================================
module a2d_slot_avg
    import a2d_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cap_i,
    input  logic [C_SAMP_W-1:0] samp_i,
    output logic [C_SAMP_W-1:0] res_o
);

`ifdef A2D_SEQ_AVG_EN
    logic [C_SAMP_W-1:0] hist_q [C_AVG_DEPTH];
    logic [C_ACC_W-1:0]  acc_q;

    // Accumulator always equals the sum of the history, so the subtraction never underflows.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            for (int i = 0; i < C_AVG_DEPTH; i++) hist_q[i] <= '0;
        end else if (cap_i) begin
            acc_q     <= acc_q - C_ACC_W'(hist_q[C_AVG_DEPTH-1]) + C_ACC_W'(samp_i);
            hist_q[0] <= samp_i;
            for (int i = 1; i < C_AVG_DEPTH; i++) hist_q[i] <= hist_q[i-1];
        end
    end

    assign res_o = acc_q[C_ACC_W-1 -: C_SAMP_W];
`else
    logic [C_SAMP_W-1:0] res_q;

    always_ff @(posedge clk) begin
        if (!rst_n)     res_q <= '0;
        else if (cap_i) res_q <= samp_i;
    end

    assign res_o = res_q;
`endif

endmodule
`default_nettype wire

// File: rtl/a2d_conv_seq.sv
`default_nettype none
// =============================================================================
// Module   : a2d_conv_seq
// Brief    : Round-robin SPI A2D scheduler for BATT/CURR/BRAKE/TORQUE; optional
//            4-sample averaging selected by macro A2D_SEQ_AVG_EN.
// Revision : 1.0
// =============================================================================
module a2d_conv_seq
    import a2d_seq_pkg::*;
#(
    parameter int FAST_SIM = 1,
    parameter int GAP_CYC  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] resp,
    output logic [11:0] batt,
    output logic [11:0] curr,
    output logic [11:0] brake,
    output logic [11:0] torque,
    output logic        cnv_cmplt,
    output logic [1:0]  cnv_ch
);

    localparam int C_TMR_W    = (FAST_SIM != 0) ? C_TMR_W_FAST : C_TMR_W_SLOW;
    localparam int C_GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int C_GAP_LAST = (GAP_CYC > 0) ? GAP_CYC - 1 : 0;

    logic [C_TMR_W-1:0]     tmr_q;
    state_t                 state_q, state_d;
    logic [1:0]             slot_q, slot_d;
    logic [C_GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic                   wrt_q, wrt_d;
    logic [15:0]            cmd_q, cmd_d;
    logic                   cmplt_q, cmplt_d;
    logic [1:0]             ch_q, ch_d;
    logic [C_NUM_SLOTS-1:0] w_cap;
    logic                   w_wrap;
    logic [C_SAMP_W-1:0]    w_res [C_NUM_SLOTS];
    logic [3:0]             w_resp_unused;

    assign w_resp_unused = resp[15:12];
    // The timer reaching all-ones means it wraps to 0 on this edge.
    assign w_wrap = &tmr_q;

    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        gap_cnt_d = gap_cnt_q;
        wrt_d     = 1'b0;
        cmd_d     = cmd_q;
        cmplt_d   = 1'b0;
        ch_d      = ch_q;
        w_cap     = '0;
        case (state_q)
            IDLE: begin
                if (w_wrap) begin
                    wrt_d   = 1'b1;
                    cmd_d   = cmd_word(slot_q);
                    state_d = CMD;
                end
            end
            CMD: begin
                if (done) begin
                    gap_cnt_d = '0;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == C_GAP_W'(C_GAP_LAST)) begin
                    wrt_d   = 1'b1;
                    cmd_d   = 16'h0000;
                    state_d = RD;
                end else begin
                    gap_cnt_d = gap_cnt_q + C_GAP_W'(1);
                end
            end
            RD: begin
                if (done) begin
                    w_cap[slot_q] = 1'b1;
                    cmplt_d       = 1'b1;
                    ch_d          = slot_q;
                    if (slot_q == 2'd3) begin
                        slot_d  = 2'd0;
                        state_d = IDLE;
                    end else begin
                        slot_d  = slot_q + 2'd1;
                        wrt_d   = 1'b1;
                        cmd_d   = cmd_word(slot_q + 2'd1);
                        state_d = CMD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmr_q     <= '0;
            state_q   <= IDLE;
            slot_q    <= 2'd0;
            gap_cnt_q <= '0;
            wrt_q     <= 1'b0;
            cmd_q     <= 16'h0000;
            cmplt_q   <= 1'b0;
            ch_q      <= 2'd0;
        end else begin
            tmr_q     <= tmr_q + C_TMR_W'(1);
            state_q   <= state_d;
            slot_q    <= slot_d;
            gap_cnt_q <= gap_cnt_d;
            wrt_q     <= wrt_d;
            cmd_q     <= cmd_d;
            cmplt_q   <= cmplt_d;
            ch_q      <= ch_d;
        end
    end

    for (genvar g = 0; g < C_NUM_SLOTS; g++) begin : g_slot
        a2d_slot_avg u_slot (
            .clk    (clk),
            .rst_n  (rst_n),
            .cap_i  (w_cap[g]),
            .samp_i (resp[C_SAMP_W-1:0]),
            .res_o  (w_res[g])
        );
    end

    assign wrt       = wrt_q;
    assign cmd       = cmd_q;
    assign cnv_cmplt = cmplt_q;
    assign cnv_ch    = ch_q;
    assign batt      = w_res[0];
    assign curr      = w_res[1];
    assign brake     = w_res[2];
    assign torque    = w_res[3];

endmodule
`default_nettype wire

// File: tb/tb_a2d_conv_seq.sv
`default_nettype none
// =============================================================================
// Module   : tb_a2d_conv_seq
// Brief    : Transaction-level reference model and SPI responder for a2d_conv_seq.
// Revision : 1.0
// =============================================================================
module tb_a2d_conv_seq;

    localparam int GAP    = 2;
    localparam int PERIOD = 1024;

`ifdef A2D_SEQ_AVG_EN
    localparam logic [11:0] C_ABC_RES   = 12'h2AF;
    localparam int          C_AVG_EXP[4] = '{100, 300, 500, 700};
`else
    localparam logic [11:0] C_ABC_RES   = 12'hABC;
    localparam int          C_AVG_EXP[4] = '{400, 800, 800, 800};
`endif
    localparam int CHMAP[4]   = '{0, 1, 3, 4};
    localparam int AVG_SEQ[4] = '{400, 800, 800, 800};

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        done  = 1'b0;
    logic [15:0] resp  = 16'h0000;
    logic        wrt;
    logic [15:0] cmd;
    logic [11:0] batt, curr, brake, torque;
    logic        cnv_cmplt;
    logic [1:0]  cnv_ch;

    always #5 clk = ~clk;

    a2d_conv_seq #(.FAST_SIM(1), .GAP_CYC(GAP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wrt       (wrt),
        .cmd       (cmd),
        .done      (done),
        .resp      (resp),
        .batt      (batt),
        .curr      (curr),
        .brake     (brake),
        .torque    (torque),
        .cnv_cmplt (cnv_cmplt),
        .cnv_ch    (cnv_ch)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Bench control (each variable has a single writing process)
    int dly          = 32;
    int rd_mode      = 0;
    bit gap_spur_en  = 1'b0;
    bit reset_arm    = 1'b0;
    int spur_idle_req = 0;
    int spur_idle_ack = 0;
    int spur_gap_req  = 0;
    int spur_gap_ack  = 0;
    bit gap2_hit     = 1'b0;
    int rounds_done  = 0;
    int cmplt_cnt    = 0;
    int first_wrt_edge = -1;
    logic [15:0] cmd_log [4];
    int ncmd_log     = 0;
    int ch_log [4];
    int nch_log      = 0;
    int avg_k        = 0;

    // SPI responder: answers each wrt with done after dly cycles, alternating cmd/read.
    initial begin : responder
        int cnt     = 0;
        bit is_rd   = 1'b0;
        int rd_slot = 0;
        forever begin
            @(negedge clk);
            #1;
            done = 1'b0;
            if (!rst_n) begin
                cnt = 0; is_rd = 1'b0; rd_slot = 0; avg_k = 0;
            end else if (wrt) begin
                cnt = dly;
            end else if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    done = 1'b1;
                    if (is_rd) begin
                        if (rd_mode == 1) resp = 16'h0ABC;
                        else if (rd_mode == 2 && rd_slot == 0 && avg_k < 4) begin
                            resp = 16'(AVG_SEQ[avg_k]);
                            avg_k++;
                        end else resp = 16'($urandom);
                        rd_slot = (rd_slot + 1) % 4;
                    end else begin
                        resp = 16'($urandom);
                    end
                    is_rd = !is_rd;
                end
            end else if (spur_idle_req != spur_idle_ack) begin
                done = 1'b1; resp = 16'($urandom); spur_idle_ack++;
            end else if (spur_gap_req != spur_gap_ack) begin
                done = 1'b1; resp = 16'($urandom); spur_gap_ack++;
            end
        end
    end

    // Reference model: a round is 8 transactions (cmd/read per slot); checked every cycle.
    int          edge_cnt = 0;
    bit          active   = 1'b0;
    bit          outst    = 1'b0;
    int          t        = 0;
    int          nxt      = -1;
    int          exp_ch   = 0;
    logic [11:0] exp_reg [4];
    int          hist [4][4];

    always @(posedge clk) begin : model
        bit          wrap_start;
        bit          exp_w;
        bit          exp_cmplt;
        logic [15:0] exp_c;
        int          s;
        int          sum;
        #1;
        if (!rst_n) begin
            edge_cnt = 0; active = 1'b0; outst = 1'b0; t = 0; nxt = -1; exp_ch = 0;
            for (int i = 0; i < 4; i++) begin
                exp_reg[i] = 12'h000;
                for (int j = 0; j < 4; j++) hist[i][j] = 0;
            end
            chk("rst_wrt", 32'(wrt), 0);
            chk("rst_cmd", 32'(cmd), 0);
            chk("rst_cnv_cmplt", 32'(cnv_cmplt), 0);
            chk("rst_cnv_ch", 32'(cnv_ch), 0);
            chk("rst_regs", {batt, curr, brake, torque}, 0);
        end else begin
            edge_cnt++;
            exp_cmplt  = 1'b0;
            wrap_start = !active && (edge_cnt % PERIOD == 0);
            if (done && outst) begin
                outst = 1'b0;
                if (t % 2 == 1) begin
                    s = t / 2;
                    for (int j = 3; j > 0; j--) hist[s][j] = hist[s][j-1];
                    hist[s][0] = int'(resp[11:0]);
`ifdef A2D_SEQ_AVG_EN
                    sum = hist[s][0] + hist[s][1] + hist[s][2] + hist[s][3];
                    exp_reg[s] = 12'(sum / 4);
`else
                    sum = hist[s][0];
                    exp_reg[s] = 12'(sum);
`endif
                    exp_cmplt = 1'b1;
                    exp_ch    = s;
                    if (t == 7) begin
                        active = 1'b0;
                        rounds_done++;
                    end else begin
                        t++;
                        nxt = edge_cnt;
                    end
                end else begin
                    t++;
                    nxt = edge_cnt + GAP;
                    if (gap_spur_en) spur_gap_req++;
                    if (reset_arm && t == 5) gap2_hit = 1'b1;
                end
            end
            if (wrap_start) begin
                active = 1'b1; t = 0; nxt = edge_cnt;
            end
            exp_w = active && (nxt == edge_cnt);
            exp_c = (t % 2 == 0) ? {2'b00, 3'(CHMAP[t/2]), 11'h000} : 16'h0000;
            chk("wrt", 32'(wrt), 32'(exp_w));
            if (exp_w) begin
                chk("cmd", 32'(cmd), 32'(exp_c));
                outst = 1'b1;
            end
            if (wrt) begin
                if (first_wrt_edge < 0) first_wrt_edge = edge_cnt;
                if (t % 2 == 0 && ncmd_log < 4) begin
                    cmd_log[ncmd_log] = cmd;
                    ncmd_log++;
                end
            end
            chk("cnv_cmplt", 32'(cnv_cmplt), 32'(exp_cmplt));
            if (cnv_cmplt) begin
                cmplt_cnt++;
                if (nch_log < 4) begin
                    ch_log[nch_log] = int'(cnv_ch);
                    nch_log++;
                end
            end
            if (exp_cmplt) chk("cnv_ch", 32'(cnv_ch), 32'(exp_ch));
            chk("batt", 32'(batt), 32'(exp_reg[0]));
            chk("curr", 32'(curr), 32'(exp_reg[1]));
            chk("brake", 32'(brake), 32'(exp_reg[2]));
            chk("torque", 32'(torque), 32'(exp_reg[3]));
        end
    end

    task automatic wait_rounds(input int n, input int budget);
        int target = rounds_done + n;
        int cyc    = 0;
        while (rounds_done < target && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (rounds_done < target) begin
            n_fail++;
            $display("FAIL round_timeout rounds=%0d required=%0d", rounds_done, target);
        end
    endtask

    initial begin : main
        int c0;
        int cyc;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // First round: fixed read data, pinned timing and command words
        rd_mode = 1;
        wait_rounds(1, 2500);
        chk("first_wrt_edge", first_wrt_edge, 1024);
        chk("cmd0", 32'(cmd_log[0]), 32'h0000);
        chk("cmd1", 32'(cmd_log[1]), 32'h0800);
        chk("cmd2", 32'(cmd_log[2]), 32'h1800);
        chk("cmd3", 32'(cmd_log[3]), 32'h2000);
        for (int i = 0; i < 4; i++) chk($sformatf("ch_seq%0d", i), ch_log[i], i);
        chk("abc_batt", 32'(batt), 32'(C_ABC_RES));
        chk("abc_curr", 32'(curr), 32'(C_ABC_RES));
        chk("abc_brake", 32'(brake), 32'(C_ABC_RES));
        chk("abc_torque", 32'(torque), 32'(C_ABC_RES));

        // Random data with spurious done pulses in IDLE and GAP
        rd_mode     = 0;
        gap_spur_en = 1'b1;
        c0          = cmplt_cnt;
        spur_idle_req++;
        wait_rounds(1, 2500);
        spur_idle_req++;
        wait_rounds(2, 4000);
        gap_spur_en = 1'b0;
        chk("cmplt_per_3_rounds", cmplt_cnt - c0, 12);

        // Reset during the GAP of slot 2
        reset_arm = 1'b1;
        cyc = 0;
        while (!gap2_hit && cyc < 2500) begin
            @(negedge clk);
            cyc++;
        end
        chk("gap2_reached", 32'(gap2_hit), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        reset_arm = 1'b0;

        // Averaging sequence on BATT right after reset
        rd_mode = 2;
        for (int k = 0; k < 4; k++) begin
            wait_rounds(1, 2500);
            chk($sformatf("avg_batt%0d", k), 32'(batt), 32'(C_AVG_EXP[k]));
        end

        // Slow responder: rounds outlast the interval, wraps must be dropped
        rd_mode = 0;
        dly     = 300;
        wait_rounds(3, 12000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
